// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer
// Control sequencer for the iterative multiplier/divider feeding HI/LO.
// Accepts a mult/div request while idle, loads the selected unit, runs it
// for ITER iterations, then writes HI/LO. A zero divisor skips the divider
// entirely and raises a one-cycle divzero/done pulse instead.
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | waiting for mult_req / div_req; busy low
// M_LOAD | load multiplier operands (mloadab)
// M_RUN  | multiplier iterating (mult), ITER cycles
// M_WB   | write HI/LO from multiplier, done pulse
// D_LOAD | load divider operands (dloadab)
// D_RUN  | divider iterating (div), ITER cycles
// D_WB   | write HI/LO from divider remainder/quotient, done pulse
// D_ZERO | divisor was zero: divzero + done pulse, no writes
//
// CNT_W must satisfy 2**CNT_W > ITER so the terminal count fits.
module muldiv_sequencer #(
  parameter int ITER  = 32,
  parameter int CNT_W = 6
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mult_req,
  input  logic        div_req,
  input  logic [31:0] divisor,
  output logic        mloadab,
  output logic        mult,
  output logic        dloadab,
  output logic        div,
  output logic        muxhigh,
  output logic        muxlow,
  output logic        highwrite,
  output logic        lowwrite,
  output logic        busy,
  output logic        done,
  output logic        divzero
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    M_LOAD = 3'd1,
    M_RUN  = 3'd2,
    M_WB   = 3'd3,
    D_LOAD = 3'd4,
    D_RUN  = 3'd5,
    D_WB   = 3'd6,
    D_ZERO = 3'd7
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITER - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;

  // Next-state selection; multiply wins when both requests are high.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (mult_req) begin
          state_nxt = M_LOAD;
        end else if (div_req) begin
          state_nxt = (divisor == 32'd0) ? D_ZERO : D_LOAD;
        end
      end
      M_LOAD:  state_nxt = M_RUN;
      M_RUN:   if (cnt == CNT_LAST) state_nxt = M_WB;
      M_WB:    state_nxt = IDLE;
      D_LOAD:  state_nxt = D_RUN;
      D_RUN:   if (cnt == CNT_LAST) state_nxt = D_WB;
      D_WB:    state_nxt = IDLE;
      D_ZERO:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register and iteration counter; counter is only cleared in LOAD.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (state == M_LOAD || state == D_LOAD) begin
        cnt <= '0;
      end else if (state == M_RUN || state == D_RUN) begin
        cnt <= cnt + CNT_ONE;
      end
    end
  end

  // Registered Moore outputs: decoded from the state being entered so that
  // each output register mirrors the current state with no combinational path.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mloadab   <= 1'b0;
      mult      <= 1'b0;
      dloadab   <= 1'b0;
      div       <= 1'b0;
      muxhigh   <= 1'b0;
      muxlow    <= 1'b0;
      highwrite <= 1'b0;
      lowwrite  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      divzero   <= 1'b0;
    end else begin
      mloadab   <= (state_nxt == M_LOAD);
      mult      <= (state_nxt == M_RUN);
      dloadab   <= (state_nxt == D_LOAD);
      div       <= (state_nxt == D_RUN);
      muxhigh   <= (state_nxt == D_WB);
      muxlow    <= (state_nxt == D_WB);
      highwrite <= (state_nxt == M_WB) || (state_nxt == D_WB);
      lowwrite  <= (state_nxt == M_WB) || (state_nxt == D_WB);
      busy      <= (state_nxt != IDLE);
      done      <= (state_nxt == M_WB) || (state_nxt == D_WB) || (state_nxt == D_ZERO);
      divzero   <= (state_nxt == D_ZERO);
    end
  end

endmodule
